// File: rtl/dram_init_arbiter.sv
// dram_init_arbiter: hands the DDR3 UI command and write-data channels to the
// DRAM initializer after reset. Once the initializer reports done, it leaves a
// one-cycle quiet gap and then gives the channels to the ORAM backend for good.
// It also tracks the initializer command/data balance and flags protocol errors.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_RESET_GAP | first cycle after reset; channels idle
// ST_INIT      | initializer owns the DRAM channels
// ST_SETTLE    | one quiet cycle between owners; channels idle
// ST_RUN       | backend owns the DRAM channels (terminal)
module dram_init_arbiter #(
  parameter int DDRAWidth = 28,
  parameter int DDRCWidth = 3,
  parameter int DDRDWidth = 512,
  parameter int DDRMWidth = 64,
  parameter int BalWidth  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [DDRAWidth-1:0] i_init_cmd_addr,
  input  logic [DDRCWidth-1:0] i_init_cmd,
  input  logic                 i_init_cmd_valid,
  output logic                 o_init_cmd_ready,
  input  logic [DDRDWidth-1:0] i_init_wr_data,
  input  logic [DDRMWidth-1:0] i_init_wr_mask,
  input  logic                 i_init_wr_valid,
  output logic                 o_init_wr_ready,
  input  logic                 i_init_done,
  input  logic [DDRAWidth-1:0] i_be_cmd_addr,
  input  logic [DDRCWidth-1:0] i_be_cmd,
  input  logic                 i_be_cmd_valid,
  output logic                 o_be_cmd_ready,
  input  logic [DDRDWidth-1:0] i_be_wr_data,
  input  logic [DDRMWidth-1:0] i_be_wr_mask,
  input  logic                 i_be_wr_valid,
  output logic                 o_be_wr_ready,
  output logic [DDRAWidth-1:0] o_dram_cmd_addr,
  output logic [DDRCWidth-1:0] o_dram_cmd,
  output logic                 o_dram_cmd_valid,
  input  logic                 i_dram_cmd_ready,
  output logic [DDRDWidth-1:0] o_dram_wr_data,
  output logic [DDRMWidth-1:0] o_dram_wr_mask,
  output logic                 o_dram_wr_valid,
  input  logic                 i_dram_wr_ready,
  output logic                 o_backend_enabled,
  output logic [1:0]           o_error
);

  typedef enum logic [1:0] {
    ST_RESET_GAP = 2'd0,
    ST_INIT      = 2'd1,
    ST_SETTLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  localparam logic signed [BalWidth-1:0] BAL_MAX = {1'b0, {(BalWidth-1){1'b1}}};
  localparam logic signed [BalWidth-1:0] BAL_MIN = {1'b1, {(BalWidth-1){1'b0}}};
  localparam logic signed [BalWidth-1:0] BAL_ONE = {{(BalWidth-1){1'b0}}, 1'b1};

  state_t                      r_state;
  logic signed [BalWidth-1:0]  r_balance;
  logic [1:0]                  r_error;
  logic                        r_backend_en;

  logic w_in_init;
  logic w_in_run;
  logic w_init_cmd_hs;
  logic w_init_wr_hs;
  logic w_init_any_valid;

  assign w_in_init        = (r_state == ST_INIT);
  assign w_in_run         = (r_state == ST_RUN);
  assign w_init_cmd_hs    = w_in_init & i_init_cmd_valid & i_dram_cmd_ready;
  assign w_init_wr_hs     = w_in_init & i_init_wr_valid & i_dram_wr_ready;
  assign w_init_any_valid = i_init_cmd_valid | i_init_wr_valid;

  // Payload follows the initializer in every state except RUN; valids and
  // readies are gated so nothing moves during RESET_GAP or SETTLE.
  assign o_dram_cmd_addr  = w_in_run ? i_be_cmd_addr : i_init_cmd_addr;
  assign o_dram_cmd       = w_in_run ? i_be_cmd      : i_init_cmd;
  assign o_dram_wr_data   = w_in_run ? i_be_wr_data  : i_init_wr_data;
  assign o_dram_wr_mask   = w_in_run ? i_be_wr_mask  : i_init_wr_mask;
  assign o_dram_cmd_valid = (w_in_init & i_init_cmd_valid) | (w_in_run & i_be_cmd_valid);
  assign o_dram_wr_valid  = (w_in_init & i_init_wr_valid)  | (w_in_run & i_be_wr_valid);
  assign o_init_cmd_ready = w_in_init & i_dram_cmd_ready;
  assign o_init_wr_ready  = w_in_init & i_dram_wr_ready;
  assign o_be_cmd_ready   = w_in_run & i_dram_cmd_ready;
  assign o_be_wr_ready    = w_in_run & i_dram_wr_ready;

  assign o_backend_enabled = r_backend_en;
  assign o_error           = r_error;

  // Ownership FSM with balance tracking and sticky error flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_RESET_GAP;
      r_balance    <= '0;
      r_error      <= 2'b00;
      r_backend_en <= 1'b0;
    end else begin
      case (r_state)
        ST_RESET_GAP: r_state <= ST_INIT;
        ST_INIT: begin
          if (w_init_cmd_hs && !w_init_wr_hs && (r_balance != BAL_MAX))
            r_balance <= r_balance + BAL_ONE;
          else if (w_init_wr_hs && !w_init_cmd_hs && (r_balance != BAL_MIN))
            r_balance <= r_balance - BAL_ONE;
          // A handshake in the done cycle holds INIT so that beat is not lost.
          if (i_init_done && !w_init_cmd_hs && !w_init_wr_hs) begin
            r_state <= ST_SETTLE;
            if (r_balance != '0) r_error[0] <= 1'b1;
          end
        end
        ST_SETTLE: begin
          r_state      <= ST_RUN;
          r_backend_en <= 1'b1;
        end
        ST_RUN:  r_state <= ST_RUN;
        default: r_state <= ST_RESET_GAP;
      endcase
      if ((r_state == ST_SETTLE || r_state == ST_RUN) && w_init_any_valid)
        r_error[1] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dram_init_arbiter.sv
// Directed bench for dram_init_arbiter: reset, balanced and imbalanced init,
// done coinciding with a handshake, backend blocking, late init valid.
module tb_dram_init_arbiter;
  localparam int DDRAWidth = 28;
  localparam int DDRCWidth = 3;
  localparam int DDRDWidth = 512;
  localparam int DDRMWidth = 64;
  localparam int BalWidth  = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [DDRAWidth-1:0] init_cmd_addr, be_cmd_addr, dram_cmd_addr;
  logic [DDRCWidth-1:0] init_cmd, be_cmd, dram_cmd;
  logic                 init_cmd_valid, init_cmd_ready, be_cmd_valid, be_cmd_ready;
  logic [DDRDWidth-1:0] init_wr_data, be_wr_data, dram_wr_data;
  logic [DDRMWidth-1:0] init_wr_mask, be_wr_mask, dram_wr_mask;
  logic                 init_wr_valid, init_wr_ready, be_wr_valid, be_wr_ready;
  logic                 init_done;
  logic                 dram_cmd_valid, dram_cmd_ready, dram_wr_valid, dram_wr_ready;
  logic                 backend_enabled;
  logic [1:0]           error;

  int vectors = 0;
  int miscompares = 0;
  int n_cmd = 0;
  int n_wr = 0;

  dram_init_arbiter #(
    .DDRAWidth(DDRAWidth), .DDRCWidth(DDRCWidth), .DDRDWidth(DDRDWidth),
    .DDRMWidth(DDRMWidth), .BalWidth(BalWidth)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_init_cmd_addr(init_cmd_addr), .i_init_cmd(init_cmd),
    .i_init_cmd_valid(init_cmd_valid), .o_init_cmd_ready(init_cmd_ready),
    .i_init_wr_data(init_wr_data), .i_init_wr_mask(init_wr_mask),
    .i_init_wr_valid(init_wr_valid), .o_init_wr_ready(init_wr_ready),
    .i_init_done(init_done),
    .i_be_cmd_addr(be_cmd_addr), .i_be_cmd(be_cmd),
    .i_be_cmd_valid(be_cmd_valid), .o_be_cmd_ready(be_cmd_ready),
    .i_be_wr_data(be_wr_data), .i_be_wr_mask(be_wr_mask),
    .i_be_wr_valid(be_wr_valid), .o_be_wr_ready(be_wr_ready),
    .o_dram_cmd_addr(dram_cmd_addr), .o_dram_cmd(dram_cmd),
    .o_dram_cmd_valid(dram_cmd_valid), .i_dram_cmd_ready(dram_cmd_ready),
    .o_dram_wr_data(dram_wr_data), .o_dram_wr_mask(dram_wr_mask),
    .o_dram_wr_valid(dram_wr_valid), .i_dram_wr_ready(dram_wr_ready),
    .o_backend_enabled(backend_enabled), .o_error(error)
  );

  always #5 clk = ~clk;

  // Count beats that actually cross the DRAM UI.
  always @(posedge clk) begin
    if (dram_cmd_valid && dram_cmd_ready) n_cmd <= n_cmd + 1;
    if (dram_wr_valid && dram_wr_ready)   n_wr  <= n_wr + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int cmd_i;
    int dat_i;
    int guard;
    int base_cmd;
    int base_wr;

    rst_n          = 1'b0;
    init_cmd_addr  = 28'h55;
    init_cmd       = 3'd1;
    init_cmd_valid = 1'b1;
    init_wr_data   = {8{64'h1111}};
    init_wr_mask   = '0;
    init_wr_valid  = 1'b1;
    init_done      = 1'b0;
    be_cmd_addr    = 28'h40;
    be_cmd         = 3'd0;
    be_cmd_valid   = 1'b1;
    be_wr_data     = {8{64'hBEBE}};
    be_wr_mask     = '1;
    be_wr_valid    = 1'b1;
    dram_cmd_ready = 1'b1;
    dram_wr_ready  = 1'b1;

    // Reset held: everything idle even with all sources requesting.
    step();
    step();
    chk("rst_valids", {dram_cmd_valid, dram_wr_valid}, 2'b00);
    chk("rst_readies", {init_cmd_ready, init_wr_ready, be_cmd_ready, be_wr_ready}, 4'b0000);
    chk("rst_be_en", backend_enabled, 1'b0);
    chk("rst_error", error, 2'b00);

    // Released: one RESET_GAP cycle, still idle.
    rst_n = 1'b1;
    #1;
    chk("gap_valids", {dram_cmd_valid, dram_wr_valid}, 2'b00);
    chk("gap_readies", {init_cmd_ready, init_wr_ready, be_cmd_ready, be_wr_ready}, 4'b0000);

    // First edge: INIT, initializer drives the DRAM channel.
    step();
    chk("init_cmd_valid", dram_cmd_valid, 1'b1);
    chk("init_cmd_addr", 64'(dram_cmd_addr), 64'h55);
    chk("init_cmd_ready_hi", init_cmd_ready, 1'b1);
    init_cmd_valid = 1'b0;
    init_wr_valid  = 1'b0;
    dram_cmd_ready = 1'b0;
    #1;
    chk("init_cmd_ready_lo", init_cmd_ready, 1'b0);
    dram_cmd_ready = 1'b1;
    #1;
    chk("init_cmd_ready_hi2", init_cmd_ready, 1'b1);
    chk("blk_be_cmd_ready", be_cmd_ready, 1'b0);
    chk("blk_be_wr_ready", be_wr_ready, 1'b0);
    chk("blk_dram_valid", dram_cmd_valid, 1'b0);
    chk("blk_dram_addr", 64'(dram_cmd_addr), 64'h55);

    // Balanced init: 4 commands and 4 data beats with random readies.
    base_cmd = n_cmd;
    base_wr  = n_wr;
    cmd_i = 0;
    dat_i = 0;
    guard = 0;
    while ((cmd_i < 4 || dat_i < 4) && guard < 200) begin
      init_cmd_valid = (cmd_i < 4);
      init_cmd_addr  = 28'(cmd_i * 8);
      init_wr_valid  = (dat_i < 4);
      init_wr_data   = {8{64'(dat_i) + 64'h1000}};
      dram_cmd_ready = 1'($urandom_range(0, 1));
      dram_wr_ready  = 1'($urandom_range(0, 1));
      #1;
      if (guard < 3) begin
        chk("bal_cmd_ready", init_cmd_ready, dram_cmd_ready);
        chk("bal_wr_ready", init_wr_ready, dram_wr_ready);
        chk("bal_be_blocked", be_cmd_ready, 1'b0);
      end
      if (cmd_i < 4) chk("bal_cmd_addr", 64'(dram_cmd_addr), 64'(cmd_i * 8));
      if (dat_i < 4) chk("bal_wr_data", dram_wr_data[63:0], 64'(dat_i) + 64'h1000);
      step();
      if (init_cmd_valid && dram_cmd_ready) cmd_i++;
      if (init_wr_valid && dram_wr_ready) dat_i++;
      guard++;
    end
    init_cmd_valid = 1'b0;
    init_wr_valid  = 1'b0;
    dram_cmd_ready = 1'b1;
    dram_wr_ready  = 1'b1;
    chk("bal_n_cmd", 64'(n_cmd - base_cmd), 64'd4);
    chk("bal_n_wr", 64'(n_wr - base_wr), 64'd4);

    // Done with no handshake: SETTLE at this edge, RUN at the next.
    init_done = 1'b1;
    step();
    init_done = 1'b0;
    chk("settle_valids", {dram_cmd_valid, dram_wr_valid}, 2'b00);
    chk("settle_readies", {init_cmd_ready, init_wr_ready, be_cmd_ready, be_wr_ready}, 4'b0000);
    chk("settle_be_en", backend_enabled, 1'b0);
    step();
    chk("run_be_en", backend_enabled, 1'b1);
    chk("run_error", error, 2'b00);
    chk("run_cmd_addr", 64'(dram_cmd_addr), 64'h40);
    chk("run_cmd_valid", dram_cmd_valid, 1'b1);
    chk("run_readies", {init_cmd_ready, init_wr_ready, be_cmd_ready, be_wr_ready}, 4'b0011);
    base_cmd = n_cmd;
    step();
    chk("run_be_accept", 64'(n_cmd - base_cmd), 64'd1);
    be_wr_valid = 1'b0;

    // Late init valid in RUN: not forwarded, raises Error[1].
    init_wr_valid = 1'b1;
    #1;
    chk("late_wr_valid", dram_wr_valid, 1'b0);
    chk("late_wr_ready", init_wr_ready, 1'b0);
    step();
    chk("late_error", error, 2'b10);
    init_wr_valid = 1'b0;

    // Reset mid-RUN clears everything at once.
    rst_n = 1'b0;
    #1;
    chk("midrst_error", error, 2'b00);
    chk("midrst_be_en", backend_enabled, 1'b0);
    chk("midrst_cmd_valid", dram_cmd_valid, 1'b0);
    be_cmd_valid = 1'b0;

    // Imbalance: 3 commands, 2 data beats.
    step();
    rst_n = 1'b1;
    step();
    base_cmd = n_cmd;
    base_wr  = n_wr;
    init_cmd_valid = 1'b1;
    init_wr_valid  = 1'b1;
    step();
    step();
    init_wr_valid = 1'b0;
    step();
    init_cmd_valid = 1'b0;
    init_done = 1'b1;
    step();
    init_done = 1'b0;
    chk("imb_n_cmd", 64'(n_cmd - base_cmd), 64'd3);
    chk("imb_n_wr", 64'(n_wr - base_wr), 64'd2);
    step();
    chk("imb_error", error, 2'b01);
    chk("imb_be_en", backend_enabled, 1'b1);

    // Done coincides with the final data beat: INIT held one cycle.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    base_wr = n_wr;
    init_cmd_valid = 1'b1;
    step();
    init_cmd_valid = 1'b0;
    init_wr_valid  = 1'b1;
    init_done      = 1'b1;
    step();
    init_wr_valid = 1'b0;
    #1;
    chk("sim_beat_taken", 64'(n_wr - base_wr), 64'd1);
    chk("sim_still_init", init_wr_ready, 1'b1);
    chk("sim_be_en0", backend_enabled, 1'b0);
    step();
    init_done = 1'b0;
    chk("sim_settle", init_wr_ready, 1'b0);
    chk("sim_settle_be_en", backend_enabled, 1'b0);
    step();
    chk("sim_error", error, 2'b00);
    chk("sim_be_en1", backend_enabled, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
